// File: rtl/core_pkg.sv
// Shared types and encodings for the MIPS core pipeline control logic.
package core_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_MSTALL,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_J   = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/redirect decisions, boot flush,
// halt/drain handshake and stall/flush performance counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int BOOT_CYCLES  = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             halt_req,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             ctrl_flush,
    output logic             pipe_we,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MAXC = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_mstall;
    logic          w_load_use;
    logic          w_in_run;
    logic          w_inc_stall;
    logic          w_inc_flush;

    assign w_mstall   = icache_stall | dcache_stall;
    assign w_load_use = ex_memread && (ex_rt != REG_ZERO) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_cnt   <= CW'(BOOT_CYCLES - 1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        pc_we       = 1'b1;
        pc_sel      = PCSEL_SEQ;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        ctrl_flush  = 1'b1;
        pipe_we     = 1'b1;
        halt_ack    = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_BOOT: begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
                ctrl_flush = 1'b0;
                if (r_cnt == '0) w_state_nxt = ST_RUN;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_RUN, ST_MSTALL: begin
                if (w_mstall) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    pipe_we     = 1'b0;
                    w_state_nxt = ST_MSTALL;
                end else begin
                    w_state_nxt = ST_RUN;
                    if (ex_branch_taken) begin
                        pc_sel     = PCSEL_BR;
                        ifid_flush = 1'b1;
                        ctrl_flush = 1'b0;
                    end else if (id_jump) begin
                        pc_sel     = PCSEL_J;
                        ifid_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        ctrl_flush = 1'b0;
                    end
                    // halt is only taken from RUN; from MSTALL it waits one more cycle
                    if ((r_state == ST_RUN) && halt_req) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = CW'(DRAIN_CYCLES - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (w_mstall) begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    pipe_we = 1'b0;
                end else begin
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                    ctrl_flush = 1'b0;
                    if (r_cnt == '0) w_state_nxt = ST_HALTED;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_HALTED: begin
                halt_ack   = 1'b1;
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                pipe_we    = 1'b0;
                ctrl_flush = 1'b0;
                if (!halt_req) w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_cnt_nxt   = CW'(BOOT_CYCLES - 1);
            end
        endcase
    end

    assign w_in_run    = (r_state == ST_RUN) || (r_state == ST_MSTALL);
    assign w_inc_stall = w_in_run && !pc_we;
    assign w_inc_flush = w_in_run && ifid_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .inc (w_inc_stall),
        .clr (rst),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .inc (w_inc_flush),
        .clr (rst),
        .q   (flush_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides each cycle whether PC, IF/ID and the downstream pipeline registers advance, hold or are squashed.
- Drives the active-low ctrl_flush input of the main decoder; 0 forces all decoded control to 0, i.e. a bubble.
- Also runs the post-reset pipeline flush, the halt/drain handshake, and saturating stall/flush performance counters.

Parameters:
BOOT_CYCLES, 4, bubble cycles injected after reset before normal fetch (>=1)
DRAIN_CYCLES, 4, bubble cycles injected after halt_req before halt_ack (>=1)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_memread  in  1  EX instruction is lw
ex_rt  in  5  destination rt of the EX instruction
ex_branch_taken  in  1  EX holds a taken beq/bne
id_jump  in  1  ID holds j/jal
icache_stall  in  1  instruction cache miss in progress
dcache_stall  in  1  data cache miss in progress
halt_req  in  1  level request to stop and drain the core
pc_we  out  1  PC register write enable
pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  load NOP into IF/ID (dominates ifid_we)
ctrl_flush  out  1  active-low bubble into ID/EX control
pipe_we  out  1  write enable for ID/EX, EX/MEM, MEM/WB
halt_ack  out  1  core drained and frozen
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of redirect cycles

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high. All state is updated on the rising edge of clk.
- State is held in registers: FSM {BOOT, RUN, MSTALL, DRAIN, HALTED}, down-counter cnt, stall_cnt and flush_cnt.
- All outputs are combinational from state and inputs.
- Reset: state=BOOT, cnt=BOOT_CYCLES-1, stall_cnt=0, flush_cnt=0. Outputs during and after reset follow the BOOT row.
- Default action set ("advance"): pc_we=1, pc_sel=00, ifid_we=1, ifid_flush=0, ctrl_flush=1, pipe_we=1, halt_ack=0.
- BOOT:
  - Outputs: pc_we=0, ifid_flush=1, ctrl_flush=0, pipe_we=1.
  - cnt decrements each cycle; at cnt==0 go to RUN.
  - Inputs are ignored. Exactly BOOT_CYCLES bubble cycles occur after rst deasserts.
- RUN / MSTALL: first matching rule applies.
  1. icache_stall|dcache_stall: freeze. pc_we=0, ifid_we=0, pipe_we=0, ctrl_flush=1 (hold, not bubble). Next state MSTALL.
  2. ex_branch_taken: pc_sel=01, ifid_flush=1, ctrl_flush=0. Squashes both younger instructions, so any load-use condition is moot.
  3. id_jump: pc_sel=10, ifid_flush=1, ctrl_flush=1 (the jal itself proceeds).
  4. Load-use when ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)): pc_we=0, ifid_we=0, ctrl_flush=0, pipe_we=1. One bubble per occurrence.
  5. Otherwise advance.
  - Branch in EX and jump in ID in the same cycle: branch wins (older instruction).
- MSTALL to RUN: in the first cycle both stalls are low, rules 2–5 apply and the next state is RUN.
  - A redirect held frozen across a stall is applied exactly once, in that release cycle.
- Halt entry:
  - halt_req is sampled in RUN only, in a cycle where rule 1 does not fire.
  - That cycle's rule action still happens; next state is DRAIN with cnt=DRAIN_CYCLES-1.
  - halt_req arriving in MSTALL is deferred until the return to RUN.
- DRAIN:
  - Outputs: pc_we=0, ifid_flush=1, ctrl_flush=0, pipe_we=1. Redirects and load-use are ignored.
  - A cache stall freezes everything per rule 1 and does not decrement cnt.
  - At cnt==0 (not stalled) go to HALTED.
- HALTED:
  - Outputs: halt_ack=1, pc_we=0, ifid_we=0, pipe_we=0, ctrl_flush=0.
  - When halt_req is low, go to RUN; the next cycle advances normally.
  - halt_req dropping during DRAIN does not abort the drain.
- Counters:
  - stall_cnt +1 on each RUN/MSTALL cycle with pc_we=0.
  - flush_cnt +1 on each RUN/MSTALL cycle with ifid_flush=1.
  - Both saturate at all-ones. Both cleared only by rst.
- rst asserted mid-stall, mid-drain or while HALTED returns to BOOT next cycle unconditionally.

Decomposition:
- Shared package (core_pkg): state enum; pc_sel encodings PCSEL_SEQ=2'b00, PCSEL_BR=2'b01, PCSEL_J=2'b10; constant REG_ZERO=5'd0.
- Sub-module sat_counter (parameter W, ports inc/clr, output q), instantiated twice.
- The load-use comparator is inline logic, not a sub-module.

Test Plan:
1. rst high 2 cycles, then low, BOOT_CYCLES=4 -> exactly 4 cycles with pc_we=0, ctrl_flush=0, ifid_flush=1; cycle 5 advance; counters 0.
2. ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_we=0, ifid_we=0, ctrl_flush=0, pipe_we=1; stall_cnt 0->1. Repeat with ex_rt=0 -> advance, no count.
3. dcache_stall high 3 cycles with ex_branch_taken held high -> 3 cycles all enables 0, ctrl_flush=1; release cycle pc_sel=01, ifid_flush=1, ctrl_flush=0; flush_cnt +1 only once; stall_cnt +3.
4. ex_branch_taken=1 and id_jump=1 same cycle -> pc_sel=01, ctrl_flush=0.
5. halt_req=1 in RUN, DRAIN_CYCLES=4, icache_stall pulsed 2 cycles mid-drain -> halt_ack rises 7 cycles after the sample cycle; halt_req=0 -> halt_ack=0 and advance next cycle.
6. stall held 2^CNT_W+5 cycles (CNT_W=4 build) -> stall_cnt sticks at 4'hF.
